// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - ALU operation sequencer: latch operands/select, settle, capture result and flags
module alu_op_sequencer #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] mux_result,
  input  logic             adder_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_neg,
  output logic             res_carry,
  output logic             busy,
  output logic [15:0]      res_count
);

  // A 4-bit counter covers the whole legal settle range; anything else cannot be counted.
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle_cycles
    $error("alu_op_sequencer: SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_d;
  logic [3:0] settle_cnt;
  logic       accept;
  logic       capture;
  logic       done;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // State register; reset drops any in-flight operation immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state decode plus the three single-cycle events that steer the datapath registers.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    capture = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (res_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Settle counter: loaded on accept, counts down while the mux array settles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= 4'd0;
    end else if (accept) begin
      settle_cnt <= CNT_LOAD;
    end else if (state == SETTLE && settle_cnt != 4'd0) begin
      settle_cnt <= settle_cnt - 4'd1;
    end
  end

  // Operand/select latches feeding the datapath; they hold until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      alu_sel <= 3'd0;
    end else if (accept) begin
      op_a    <= req_a;
      op_b    <= req_b;
      alu_sel <= req_op;
    end
  end

  // Result capture: the mux bus and carry are only looked at on the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_neg   <= 1'b0;
      res_carry <= 1'b0;
    end else if (capture) begin
      res_data  <= mux_result;
      res_zero  <= (mux_result == '0);
      res_neg   <= mux_result[WIDTH-1];
      res_carry <= (alu_sel[2:1] == 2'b00) ? adder_cout : 1'b0;
    end
  end

  // Result valid flag and completed-handshake counter (wraps naturally at 16 bits).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_count <= 16'd0;
    end else if (capture) begin
      res_valid <= 1'b1;
    end else if (done) begin
      res_valid <= 1'b0;
      res_count <= res_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [7:0]  req_a, req_b;
  logic [7:0]  op_a, op_b;
  logic [2:0]  alu_sel;
  logic [7:0]  mux_result;
  logic        adder_cout;
  logic        res_valid, res_ready;
  logic [7:0]  res_data;
  logic        res_zero, res_neg, res_carry, busy;
  logic [15:0] res_count;

  logic        req_valid1, req_ready1, res_valid1, res_ready1;
  logic [7:0]  op_a1, op_b1, res_data1;
  logic [2:0]  alu_sel1;
  logic        res_zero1, res_neg1, res_carry1, busy1;
  logic [15:0] res_count1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
    .alu_sel(alu_sel), .mux_result(mux_result), .adder_cout(adder_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_neg(res_neg), .res_carry(res_carry),
    .busy(busy), .res_count(res_count)
  );

  alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .op_a(op_a1), .op_b(op_b1),
    .alu_sel(alu_sel1), .mux_result(mux_result), .adder_cout(adder_cout),
    .res_valid(res_valid1), .res_ready(res_ready1), .res_data(res_data1),
    .res_zero(res_zero1), .res_neg(res_neg1), .res_carry(res_carry1),
    .busy(busy1), .res_count(res_count1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept a request and walk SETTLE_CYCLES=2 to capture; mux bus is junk until after edge k+1.
  task automatic run_txn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] mux, input logic cout);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    mux_result = ~mux; adder_cout = ~cout;
    step();
    req_valid = 1'b0;
    step();
    mux_result = mux; adder_cout = cout;
    step();
    mux_result = 8'h5A; adder_cout = ~cout;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if ({op_a, op_b, alu_sel} !== 19'd0) begin n_fail++; $display("FAIL reset_operands: got %h/%h/%h expected 0", op_a, op_b, alu_sel); end
    n_checks++; if ({res_valid, res_data, res_zero, res_neg, res_carry} !== 12'd0) begin n_fail++; $display("FAIL reset_result: got v=%b d=%h z=%b n=%b c=%b expected 0", res_valid, res_data, res_zero, res_neg, res_carry); end
    n_checks++; if (res_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %h expected 0", res_count); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++; if ({busy, res_valid, req_ready, res_count, op_a} !== {3'b001, 16'd0, 8'd0}) begin n_fail++; $display("FAIL idle_hold[%0d]: got busy=%b v=%b rdy=%b cnt=%h a=%h expected 0/0/1/0/0", i, busy, res_valid, req_ready, res_count, op_a); end
    end
  endtask

  task automatic test_add();
    req_op = 3'b000; req_a = 8'hF0; req_b = 8'h20; req_valid = 1'b1;
    mux_result = 8'h5A; adder_cout = 1'b0;
    step();
    n_checks++; if ({alu_sel, op_a, op_b} !== {3'b000, 8'hF0, 8'h20}) begin n_fail++; $display("FAIL add_latch: got sel=%b a=%h b=%h expected 000/f0/20", alu_sel, op_a, op_b); end
    n_checks++; if ({busy, req_ready, res_valid} !== 3'b100) begin n_fail++; $display("FAIL add_settle_flags: got busy=%b rdy=%b v=%b expected 1/0/0", busy, req_ready, res_valid); end
    req_valid = 1'b0; req_a = 8'h00;
    mux_result = 8'h10; adder_cout = 1'b1;
    step();
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL add_latency_early: got v=%b expected 0 after k+1", res_valid); end
    step();
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL add_latency: got v=%b expected 1 after k+2", res_valid); end
    n_checks++; if ({res_data, res_carry, res_zero, res_neg} !== {8'h10, 3'b100}) begin n_fail++; $display("FAIL add_result: got d=%h c=%b z=%b n=%b expected 10/1/0/0", res_data, res_carry, res_zero, res_neg); end
    mux_result = 8'hFF; adder_cout = 1'b0;
    handshake();
    n_checks++; if ({res_valid, req_ready, res_count} !== {2'b01, 16'd1}) begin n_fail++; $display("FAIL add_handshake: got v=%b rdy=%b cnt=%h expected 0/1/1", res_valid, req_ready, res_count); end
    n_checks++; if ({res_data, res_carry} !== {8'h10, 1'b1}) begin n_fail++; $display("FAIL add_retain: got d=%h c=%b expected 10/1", res_data, res_carry); end
  endtask

  task automatic test_logic_flags();
    run_txn(3'b010, 8'h0F, 8'hF0, 8'h00, 1'b1);
    n_checks++; if ({res_valid, res_data, res_zero, res_neg, res_carry} !== {1'b1, 8'h00, 3'b100}) begin n_fail++; $display("FAIL logic_zero: got v=%b d=%h z=%b n=%b c=%b expected 1/00/1/0/0", res_valid, res_data, res_zero, res_neg, res_carry); end
    step();
    n_checks++; if ({res_valid, res_data} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL logic_glitch_hold: got v=%b d=%h expected 1/00", res_valid, res_data); end
    handshake();
    run_txn(3'b011, 8'h01, 8'h07, 8'h80, 1'b1);
    n_checks++; if ({res_data, res_zero, res_neg, res_carry} !== {8'h80, 3'b010}) begin n_fail++; $display("FAIL logic_neg: got d=%h z=%b n=%b c=%b expected 80/0/1/0", res_data, res_zero, res_neg, res_carry); end
    handshake();
    run_txn(3'b001, 8'h05, 8'h07, 8'hFE, 1'b0);
    n_checks++; if ({res_data, res_zero, res_neg, res_carry} !== {8'hFE, 3'b010}) begin n_fail++; $display("FAIL sub_borrow: got d=%h z=%b n=%b c=%b expected fe/0/1/0", res_data, res_zero, res_neg, res_carry); end
    handshake();
    n_checks++; if (res_count !== 16'd4) begin n_fail++; $display("FAIL logic_count: got %h expected 4", res_count); end
  endtask

  task automatic test_back_pressure();
    run_txn(3'b000, 8'h11, 8'h22, 8'h33, 1'b0);
    req_op = 3'b100; req_a = 8'hAA; req_b = 8'hBB; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if ({res_valid, req_ready, res_data, res_carry, res_zero, res_neg} !== {2'b10, 8'h33, 3'b000}) begin n_fail++; $display("FAIL bp_hold_result[%0d]: got v=%b rdy=%b d=%h c=%b z=%b n=%b expected 1/0/33/0/0/0", i, res_valid, req_ready, res_data, res_carry, res_zero, res_neg); end
      n_checks++; if ({op_a, op_b, alu_sel} !== {8'h11, 8'h22, 3'b000}) begin n_fail++; $display("FAIL bp_hold_operands[%0d]: got a=%h b=%h sel=%b expected 11/22/000", i, op_a, op_b, alu_sel); end
    end
    handshake();
    n_checks++; if ({res_valid, req_ready, res_count, op_a} !== {2'b01, 16'd5, 8'h11}) begin n_fail++; $display("FAIL bp_release: got v=%b rdy=%b cnt=%h a=%h expected 0/1/5/11", res_valid, req_ready, res_count, op_a); end
    step();
    n_checks++; if ({busy, op_a, op_b, alu_sel} !== {1'b1, 8'hAA, 8'hBB, 3'b100}) begin n_fail++; $display("FAIL bp_second_accept: got busy=%b a=%h b=%h sel=%b expected 1/aa/bb/100", busy, op_a, op_b, alu_sel); end
    req_valid = 1'b0; mux_result = 8'hC3; adder_cout = 1'b1;
    step();
    step();
    n_checks++; if ({res_valid, res_data, res_carry} !== {1'b1, 8'hC3, 1'b0}) begin n_fail++; $display("FAIL bp_second_result: got v=%b d=%h c=%b expected 1/c3/0", res_valid, res_data, res_carry); end
    handshake();
    n_checks++; if (res_count !== 16'd6) begin n_fail++; $display("FAIL bp_count: got %h expected 6", res_count); end
  endtask

  task automatic test_async_reset();
    req_op = 3'b001; req_a = 8'h05; req_b = 8'h06; req_valid = 1'b1;
    mux_result = 8'h77; adder_cout = 1'b1;
    step();
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({busy, req_ready, res_valid} !== 3'b010) begin n_fail++; $display("FAIL areset_state: got busy=%b rdy=%b v=%b expected 0/1/0", busy, req_ready, res_valid); end
    n_checks++; if ({op_a, op_b, alu_sel, res_count} !== 35'd0) begin n_fail++; $display("FAIL areset_outputs: got a=%h b=%h sel=%b cnt=%h expected 0", op_a, op_b, alu_sel, res_count); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if ({res_valid, busy, res_count} !== 18'd0) begin n_fail++; $display("FAIL areset_after[%0d]: got v=%b busy=%b cnt=%h expected 0/0/0", i, res_valid, busy, res_count); end
    end
  endtask

  task automatic test_count_wrap();
    force dut.res_count = 16'hFFFF;
    #1;
    release dut.res_count;
    #1;
    n_checks++; if (res_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h expected ffff", res_count); end
    run_txn(3'b101, 8'h01, 8'h02, 8'h03, 1'b0);
    handshake();
    n_checks++; if (res_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_count: got %h expected 0000", res_count); end
  endtask

  task automatic test_settle_one();
    req_op = 3'b000; req_a = 8'h7F; req_b = 8'h01; req_valid1 = 1'b1;
    mux_result = 8'h80; adder_cout = 1'b0;
    step();
    n_checks++; if ({busy1, res_valid1, op_a1} !== {2'b10, 8'h7F}) begin n_fail++; $display("FAIL s1_accept: got busy=%b v=%b a=%h expected 1/0/7f", busy1, res_valid1, op_a1); end
    req_valid1 = 1'b0;
    step();
    n_checks++; if ({res_valid1, res_data1, res_neg1, res_carry1} !== {1'b1, 8'h80, 2'b10}) begin n_fail++; $display("FAIL s1_latency: got v=%b d=%h n=%b c=%b expected 1/80/1/0", res_valid1, res_data1, res_neg1, res_carry1); end
    res_ready1 = 1'b1;
    step();
    res_ready1 = 1'b0;
    n_checks++; if ({res_valid1, req_ready1, res_count1} !== {2'b01, 16'd1}) begin n_fail++; $display("FAIL s1_handshake: got v=%b rdy=%b cnt=%h expected 0/1/1", res_valid1, req_ready1, res_count1); end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_op = 3'd0; req_a = 8'd0; req_b = 8'd0;
    res_ready = 1'b0; mux_result = 8'd0; adder_cout = 1'b0;
    req_valid1 = 1'b0; res_ready1 = 1'b0;
    test_reset();
    test_add();
    test_logic_flags();
    test_back_pressure();
    test_async_reset();
    test_count_wrap();
    test_settle_one();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
